// File: rtl/gfx_pkg.sv
// ============================================================================
// Module : gfx_pkg
// Brief  : Shared constants and FSM state type for the sprite ROM fetch path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gfx_pkg;
  localparam int                 SDR_AW       = 22;
  localparam logic [SDR_AW-1:0]  SPR_ROM_BASE = 22'h0A0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2
  } fetch_state_t;
endpackage

`default_nettype wire

// File: rtl/spr_rom_fetch_if.sv
// ============================================================================
// Module : spr_gfx_if / sdr_rd_if
// Brief  : Sprite-engine byte fetch bus and SDRAM toggle req/ack read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface spr_gfx_if;
  logic [15:0] spr_gfx_addr;
  logic [7:0]  spr_gfx_data;
  logic        spr_gfx_rdy;

  modport master (output spr_gfx_addr, input  spr_gfx_data, spr_gfx_rdy);
  modport slave  (input  spr_gfx_addr, output spr_gfx_data, spr_gfx_rdy);
endinterface

interface sdr_rd_if #(
  parameter int AW = 22
);
  logic [AW-1:0] sdr_addr;
  logic          sdr_req;
  logic          sdr_ack;
  logic [15:0]   sdr_data;

  modport master (output sdr_addr, sdr_req, input  sdr_ack, sdr_data);
  modport slave  (input  sdr_addr, sdr_req, output sdr_ack, sdr_data);
endinterface

`default_nettype wire

// File: rtl/spr_word_cache.sv
// ============================================================================
// Module : spr_word_cache
// Brief  : 2-entry direct-mapped word cache with hit and byte-select logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spr_word_cache (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic [15:0] addr,
  input  wire logic        clr,
  input  wire logic        fill_en,
  input  wire logic        fill_ix,
  input  wire logic [13:0] fill_tag,
  input  wire logic [15:0] fill_word,
  output logic             hit,
  output logic [7:0]       data
);
  logic [1:0]  r_valid;
  logic [13:0] r_tag  [2];
  logic [15:0] r_word [2];
  logic        w_ix;
  logic [15:0] w_word;

  assign w_ix   = addr[15];
  assign w_word = r_word[w_ix];
  assign hit    = r_valid[w_ix] & (r_tag[w_ix] == addr[14:1]);
  assign data   = addr[0] ? w_word[15:8] : w_word[7:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 2'b00;
    end else if (clr) begin
      r_valid <= 2'b00;
    end else if (fill_en) begin
      r_valid[fill_ix] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      r_tag[fill_ix]  <= fill_tag;
      r_word[fill_ix] <= fill_word;
    end
  end
endmodule

`default_nettype wire

// File: rtl/spr_rom_fetch.sv
// ============================================================================
// Module : spr_rom_fetch
// Brief  : Serves sprite ROM byte fetches from SDRAM via a 2-entry word cache.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spr_rom_fetch
  import gfx_pkg::*;
#(
  parameter int            AW       = SDR_AW,
  parameter logic [AW-1:0] ROM_BASE = SPR_ROM_BASE
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  input  wire logic  dl_busy,
  spr_gfx_if.slave   gfx,
  sdr_rd_if.master   sdr
);
  fetch_state_t  r_state, w_state_nxt;
  logic          r_req,   w_req_nxt;
  logic [AW-1:0] r_addr,  w_addr_nxt;
  logic          r_ix_l,  w_ix_l_nxt;
  logic [13:0]   r_tag_l, w_tag_l_nxt;
  logic [14:0]   w_wa;
  logic          w_hit;
  logic          w_fill_en;
  logic          w_clr;

  assign w_wa            = gfx.spr_gfx_addr[15:1];
  assign gfx.spr_gfx_rdy = w_hit & ~dl_busy;
  assign sdr.sdr_addr    = r_addr;
  assign sdr.sdr_req     = r_req;

  spr_word_cache u_cache (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr      (gfx.spr_gfx_addr),
    .clr       (w_clr),
    .fill_en   (w_fill_en),
    .fill_ix   (r_ix_l),
    .fill_tag  (r_tag_l),
    .fill_word (sdr.sdr_data),
    .hit       (w_hit),
    .data      (gfx.spr_gfx_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_ix_l_nxt  = r_ix_l;
    w_tag_l_nxt = r_tag_l;
    w_fill_en   = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (dl_busy) begin
          w_clr = 1'b1;
        end else if (!w_hit) begin
          w_addr_nxt  = ROM_BASE + AW'(w_wa);
          w_req_nxt   = ~r_req;
          w_ix_l_nxt  = w_wa[14];
          w_tag_l_nxt = w_wa[13:0];
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A download started mid-read completes the handshake but drops the word.
        if (sdr.sdr_ack == r_req) begin
          w_fill_en   = ~dl_busy;
          w_state_nxt = FILL;
        end
      end
      FILL:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_ix_l  <= 1'b0;
      r_tag_l <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_ix_l  <= w_ix_l_nxt;
      r_tag_l <= w_tag_l_nxt;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_spr_rom_fetch.sv
// ============================================================================
// Module : tb_spr_rom_fetch
// Brief  : Self-checking bench for spr_rom_fetch with an SDRAM and cache model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spr_rom_fetch;
  localparam logic [21:0] BASE = 22'h0A0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dl_busy = 1'b0;

  spr_gfx_if             gfx ();
  sdr_rd_if #(.AW(22))   sdr ();

  spr_rom_fetch #(.AW(22), .ROM_BASE(BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dl_busy (dl_busy),
    .gfx     (gfx),
    .sdr     (sdr)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [32768];
  int          lat = 5;
  int          req_cnt = 0;
  logic [21:0] last_addr = '0;
  logic        last_req = 1'b0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [21:0] off;

  int tests = 0;
  int fails = 0;

  // Model cache: which word each index currently holds.
  logic        mv [2];
  logic [13:0] mt [2];

  // SDRAM controller model: answers each req toggle after lat clocks.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_req    = 1'b0;
      pend        = 1'b0;
      sdr.sdr_ack = 1'b0;
    end else if (pend) begin
      if (cnt == 0) begin
        off          = last_addr - BASE;
        sdr.sdr_data = mem[off[14:0]];
        sdr.sdr_ack  = last_req;
        pend         = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end else if (sdr.sdr_req != last_req) begin
      last_req  = sdr.sdr_req;
      req_cnt   = req_cnt + 1;
      last_addr = sdr.sdr_addr;
      pend      = 1'b1;
      cnt       = lat - 1;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!gfx.spr_gfx_rdy && n < 80) begin
      step();
      n++;
    end
    check("rdy_wait", 32'(gfx.spr_gfx_rdy), 32'd1);
  endtask

  function automatic logic [7:0] exp_byte(input logic [15:0] a);
    logic [15:0] w;
    w = mem[a[15:1]];
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic access(input logic [15:0] a);
    int   c0, n;
    logic ix, hit;
    ix  = a[15];
    hit = mv[ix] && (mt[ix] == a[14:1]);
    c0  = req_cnt;
    gfx.spr_gfx_addr = a;
    #1;
    if (hit) check("hit_same_cycle", 32'(gfx.spr_gfx_rdy), 32'd1);
    wait_rdy(n);
    check("data", 32'(gfx.spr_gfx_data), 32'(exp_byte(a)));
    check("req_delta", 32'(req_cnt - c0), hit ? 32'd0 : 32'd1);
    if (!hit) begin
      check("sdr_addr", 32'(last_addr), 32'(BASE + 22'(a[15:1])));
      check("miss_latency", 32'(n), 32'(lat + 2));
    end
    mv[ix] = 1'b1;
    mt[ix] = a[14:1];
    step();
  endtask

  initial begin
    int          c0, n, guard;
    logic        seen;
    logic [13:0] pool [3];
    logic [15:0] a;

    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hB4A3;
    pool[0] = 14'h0008; pool[1] = 14'h0009; pool[2] = 14'h1ABC;
    mv[0] = 1'b0; mv[1] = 1'b0; mt[0] = '0; mt[1] = '0;
    sdr.sdr_ack  = 1'b0;
    sdr.sdr_data = 16'h0000;
    gfx.spr_gfx_addr = 16'h0000;

    // 1: reset state, first miss, then odd byte of the same word
    step(); step();
    check("reset_rdy", 32'(gfx.spr_gfx_rdy), 32'd0);
    check("reset_req", 32'(sdr.sdr_req), 32'd0);
    check("reset_addr", 32'(sdr.sdr_addr), 32'd0);
    reset_n = 1'b1;
    lat = 5;
    access(16'h0000);
    check("first_byte", 32'(gfx.spr_gfx_data), 32'hA3);
    check("t1_data_a3", 32'(exp_byte(16'h0000)), 32'hA3);
    access(16'h0001);
    check("t1_data_b4", 32'(gfx.spr_gfx_data), 32'hB4);

    // 2: both indices live at once
    c0 = req_cnt;
    access(16'h8010);
    access(16'h0010);
    access(16'h8010);
    check("t2_total_req", 32'(req_cnt - c0), 32'd2);

    // 3: conflicting tags on entry 0
    access(16'h0012);
    check("t3_addr", 32'(last_addr), 32'h0A0009);
    access(16'h0010);

    // 4: address changes while the read is in flight
    c0 = req_cnt;
    gfx.spr_gfx_addr = 16'h0100;
    step(); step();
    gfx.spr_gfx_addr = 16'h0200;
    seen = 1'b0;
    guard = 0;
    while (req_cnt < c0 + 2 && guard < 60) begin
      step();
      seen |= gfx.spr_gfx_rdy;
      guard++;
    end
    check("t4_no_early_rdy", 32'(seen), 32'd0);
    check("t4_req_count", 32'(req_cnt - c0), 32'd2);
    check("t4_second_addr", 32'(last_addr), 32'h0A0100);
    wait_rdy(n);
    check("t4_data", 32'(gfx.spr_gfx_data), 32'(exp_byte(16'h0200)));
    mv[0] = 1'b1; mt[0] = 14'h0100;
    step();

    // 5: download starts while a read is outstanding
    c0 = req_cnt;
    gfx.spr_gfx_addr = 16'h4444;
    step();
    dl_busy = 1'b1;
    guard = 0;
    while ((req_cnt != c0 + 1 || pend) && guard < 40) begin
      step();
      guard++;
    end
    step(); step(); step();
    check("t5_busy_rdy", 32'(gfx.spr_gfx_rdy), 32'd0);
    check("t5_busy_no_req", 32'(req_cnt - c0), 32'd1);
    mv[0] = 1'b0; mv[1] = 1'b0;
    dl_busy = 1'b0;
    #1;
    check("t5_discarded", 32'(gfx.spr_gfx_rdy), 32'd0);
    wait_rdy(n);
    check("t5_rereq", 32'(req_cnt - c0), 32'd2);
    check("t5_addr", 32'(last_addr), 32'(BASE + 22'h2222));
    check("t5_data", 32'(gfx.spr_gfx_data), 32'(exp_byte(16'h4444)));
    mv[0] = 1'b1; mt[0] = 14'h2222;
    step();

    // 6: reset while waiting on SDRAM
    gfx.spr_gfx_addr = 16'h1234;
    step(); step();
    reset_n = 1'b0;
    dl_busy = 1'b1;
    step(); step();
    check("t6_reset_req", 32'(sdr.sdr_req), 32'd0);
    check("t6_reset_ack", 32'(sdr.sdr_ack), 32'd0);
    reset_n = 1'b1;
    step();
    mv[0] = 1'b0; mv[1] = 1'b0;
    dl_busy = 1'b0;
    #1;
    check("t6_valid_clear", 32'(gfx.spr_gfx_rdy), 32'd0);
    access(16'h1234);
    check("t6_req_toggled", 32'(sdr.sdr_req), 32'd1);

    // Random accesses over a small address pool to mix hits and misses
    for (int k = 0; k < 40; k++) begin
      lat = int'($urandom_range(1, 6));
      a = {1'($urandom), pool[$urandom_range(0, 2)], 1'($urandom)};
      access(a);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
